// File: rtl/pause_cen_gate_if.sv
// Signal bundle between the pause controller side and pause_cen_gate.
// step is present only when PAUSE_FRAME_STEP_EN is defined.
interface pause_cen_gate_if #(
    parameter int FW = 8
);
    logic          pause_cpu;
    logic          vblank;
    logic          cpu_busy;
`ifdef PAUSE_FRAME_STEP_EN
    logic          step;
`endif
    logic          cpu_cen;
    logic          pause_ack;
    logic [FW-1:0] frames_paused;

`ifdef PAUSE_FRAME_STEP_EN
    modport master (
        output pause_cpu, vblank, cpu_busy, step,
        input  cpu_cen, pause_ack, frames_paused
    );
    modport slave (
        input  pause_cpu, vblank, cpu_busy, step,
        output cpu_cen, pause_ack, frames_paused
    );
`else
    modport master (
        output pause_cpu, vblank, cpu_busy,
        input  cpu_cen, pause_ack, frames_paused
    );
    modport slave (
        input  pause_cpu, vblank, cpu_busy,
        output cpu_cen, pause_ack, frames_paused
    );
`endif
endinterface

// File: rtl/pause_cen_gate.sv
// Frame-aligned CPU clock-enable gate driven by a level pause request.
// Optional frame-advance (STEP) support is enabled by defining PAUSE_FRAME_STEP_EN.
module pause_cen_gate #(
    parameter int DIV      = 4,
    parameter int FW       = 8,
    parameter bit SYNC_VBL = 1'b1
) (
    input  logic           clk_sys,
    input  logic           reset_n,
    pause_cen_gate_if.slave bus
);
    localparam int DW = $clog2(DIV);

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        PAUSED,
        RESUME
`ifdef PAUSE_FRAME_STEP_EN
        , STEP
`endif
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          vbl_seen;
    logic          vbl_seen_nxt;
    logic          vblank_d;
    logic [DW-1:0] div_cnt;
    logic          cen_q;
    logic          ack_q;
    logic [FW-1:0] frames_q;
    logic          adv;
    logic          vb_rise;
    logic          div_zero;
    logic          div_last;
    logic          step_rise;

    assign vb_rise  = bus.vblank & ~vblank_d;
    assign div_zero = (div_cnt == '0);
    assign div_last = (div_cnt == DW'(DIV - 1));

`ifdef PAUSE_FRAME_STEP_EN
    logic step_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            step_d <= 1'b0;
        end else begin
            step_d <= bus.step;
        end
    end

    assign step_rise = bus.step & ~step_d;
`else
    assign step_rise = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        vbl_seen_nxt = vbl_seen;
        adv          = 1'b0;
        unique case (state)
            RUN: begin
                adv = 1'b1;
                if (bus.pause_cpu) begin
                    state_nxt    = DRAIN;
                    vbl_seen_nxt = 1'b0;
                end
            end
            DRAIN: begin
                adv = 1'b1;
                if (vb_rise) vbl_seen_nxt = 1'b1;
                // abort wins over a pause that would otherwise land now
                if (!bus.pause_cpu) begin
                    state_nxt = RUN;
                end else if ((vbl_seen | vb_rise | !SYNC_VBL) &
                             !bus.cpu_busy & div_zero) begin
                    state_nxt = PAUSED;
                end
            end
            PAUSED: begin
                if (!bus.pause_cpu) begin
                    state_nxt = RESUME;
                end else if (step_rise) begin
`ifdef PAUSE_FRAME_STEP_EN
                    state_nxt    = STEP;
                    vbl_seen_nxt = 1'b0;
`endif
                end
            end
            RESUME: begin
                if (bus.pause_cpu) begin
                    state_nxt = PAUSED;
                end else if (vb_rise || !SYNC_VBL) begin
                    state_nxt = RUN;
                end
            end
`ifdef PAUSE_FRAME_STEP_EN
            STEP: begin
                adv = 1'b1;
                if (vb_rise) vbl_seen_nxt = 1'b1;
                if (!bus.pause_cpu) begin
                    state_nxt = RUN;
                end else if ((vbl_seen | vb_rise) &
                             !bus.cpu_busy & div_zero) begin
                    state_nxt = PAUSED;
                end
            end
`endif
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            vbl_seen <= 1'b0;
            vblank_d <= 1'b0;
            div_cnt  <= '0;
            cen_q    <= 1'b0;
            ack_q    <= 1'b0;
            frames_q <= '0;
        end else begin
            state    <= state_nxt;
            vbl_seen <= vbl_seen_nxt;
            vblank_d <= bus.vblank;
            cen_q    <= adv & div_last;
            if (adv) begin
                div_cnt <= div_last ? '0 : div_cnt + DW'(1);
            end
            ack_q <= (state_nxt == PAUSED);
            // only a fresh pause clears the count; resume/step re-entries keep it
            if (state == DRAIN && state_nxt == PAUSED) begin
                frames_q <= '0;
            end else if (state == PAUSED && vb_rise && frames_q != '1) begin
                frames_q <= frames_q + FW'(1);
            end
        end
    end

    assign bus.cpu_cen       = cen_q;
    assign bus.pause_ack     = ack_q;
    assign bus.frames_paused = frames_q;
endmodule
